// File: rtl/fifo_2clk.sv
// Single-clock 32x8 FIFO with registered empty/full flags and fill count.
// Define FIFO_2CLK_SHOWAHEAD_EN to present the head word on q without waiting for rdreq.
module fifo_2clk #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  rdempty,
  output logic                  wrfull,
  output logic [ADDR_WIDTH-1:0] wrusedw
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  wr_ok, rd_ok;

  // Acceptance uses the pre-edge flags, so empty+wr+rd and full+wr+rd resolve to one side.
  assign wr_ok = wrreq & ~full_q;
  assign rd_ok = rdreq & ~empty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) wptr_d = wptr_q + PTR_ONE;
    if (rd_ok) rptr_d = rptr_q + PTR_ONE;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Storage is deliberately not cleared on reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem_q[wptr_q] <= data;
  end

`ifdef FIFO_2CLK_SHOWAHEAD_EN
  assign q = empty_q ? '0 : mem_q[rptr_q];
`else
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_ok) rdata_d = mem_q[rptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign q = rdata_q;
`endif

  assign rdempty = empty_q;
  assign wrfull  = full_q;
  assign wrusedw = count_q[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_2clk.sv
// Directed bench for fifo_2clk: a vector table for short cases plus fill/drain/simultaneous sequences.
module tb_fifo_2clk;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data = '0;
  logic       wrreq = 1'b0;
  logic       rdreq = 1'b0;
  logic [7:0] q;
  logic       rdempty;
  logic       wrfull;
  logic [4:0] wrusedw;

  int total = 0;
  int bad   = 0;

  fifo_2clk #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q), .rdempty(rdempty), .wrfull(wrfull), .wrusedw(wrusedw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       w;
    logic       rd;
    logic [7:0] d;
    logic       e_empty;
    logic       e_full;
    logic [4:0] e_used;
    logic [7:0] e_q;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic w, input logic rd, input logic [7:0] d,
                         input logic e_empty, input logic e_full, input logic [4:0] e_used,
                         input logic [7:0] e_q);
    vec_t v;
    v.r = r; v.w = w; v.rd = rd; v.d = d;
    v.e_empty = e_empty; v.e_full = e_full; v.e_used = e_used; v.e_q = e_q;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_q(input string name, input logic [7:0] exp);
`ifndef FIFO_2CLK_SHOWAHEAD_EN
    chk(name, {24'd0, q}, {24'd0, exp});
`endif
  endtask

  // Apply inputs, let one rising edge pass, and leave the time 1 unit after it for sampling.
  task automatic cyc(input logic r, input logic w, input logic rd, input logic [7:0] d);
    rst = r; wrreq = w; rdreq = rd; data = d;
    @(posedge clk);
    #1;
    rst = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
  endtask

  initial begin
    //        rst wr rd data   empty full used q
    add_vec(1, 0, 0, 8'h00,  1, 0, 5'd0, 8'h00);
    add_vec(1, 0, 0, 8'h00,  1, 0, 5'd0, 8'h00);
    add_vec(0, 0, 1, 8'h00,  1, 0, 5'd0, 8'h00);
    add_vec(0, 1, 1, 8'hAA,  0, 0, 5'd1, 8'h00);
    add_vec(0, 1, 0, 8'h55,  0, 0, 5'd2, 8'h00);
    add_vec(0, 0, 1, 8'h00,  0, 0, 5'd1, 8'hAA);
    add_vec(0, 1, 1, 8'h66,  0, 0, 5'd1, 8'h55);
    add_vec(0, 0, 1, 8'h00,  1, 0, 5'd0, 8'h66);
    add_vec(0, 0, 1, 8'h00,  1, 0, 5'd0, 8'h66);
    add_vec(1, 1, 0, 8'h77,  1, 0, 5'd0, 8'h00);
    add_vec(0, 1, 0, 8'h11,  0, 0, 5'd1, 8'h00);
    add_vec(0, 0, 1, 8'h00,  1, 0, 5'd0, 8'h11);

    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].w, vecs[i].rd, vecs[i].d);
      chk($sformatf("vec%0d_empty", i), {31'd0, rdempty}, {31'd0, vecs[i].e_empty});
      chk($sformatf("vec%0d_full", i),  {31'd0, wrfull},  {31'd0, vecs[i].e_full});
      chk($sformatf("vec%0d_used", i),  {27'd0, wrusedw}, {27'd0, vecs[i].e_used});
      chk_q($sformatf("vec%0d_q", i), vecs[i].e_q);
    end

    // Fill 1..32 from empty, then an overflow write of 33.
    for (int i = 1; i <= 32; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'(i));
      chk($sformatf("fill%0d_used", i), {27'd0, wrusedw}, 32'(i % 32));
      chk($sformatf("fill%0d_full", i), {31'd0, wrfull}, {31'd0, (i == 32)});
    end
    cyc(1'b0, 1'b1, 1'b0, 8'd33);
    chk("ovf_full", {31'd0, wrfull}, 32'd1);
    chk("ovf_used", {27'd0, wrusedw}, 32'd0);

    // Drain 33 times: 1..32 in order, the last read is ignored.
    for (int i = 1; i <= 33; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk_q($sformatf("drain%0d_q", i), (i <= 32) ? 8'(i) : 8'd32);
      chk($sformatf("drain%0d_empty", i), {31'd0, rdempty}, {31'd0, (i >= 32)});
    end

    // Ten stored words, then twenty cycles of simultaneous write and read.
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 1'b0, 8'(100 + k));
    chk("pre_sim_used", {27'd0, wrusedw}, 32'd10);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 8'(110 + k));
      chk($sformatf("sim%0d_used", k), {27'd0, wrusedw}, 32'd10);
      chk_q($sformatf("sim%0d_q", k), 8'(100 + k));
    end
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk_q($sformatf("post_sim%0d_q", k), 8'(120 + k));
    end
    chk("post_sim_empty", {31'd0, rdempty}, 32'd1);

    // Full + write + read: only the read is accepted.
    for (int i = 0; i < 32; i++) cyc(1'b0, 1'b1, 1'b0, 8'(200 + i));
    chk("refill_full", {31'd0, wrfull}, 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 8'hEE);
    chk("fullwr_used", {27'd0, wrusedw}, 32'd31);
    chk("fullwr_full", {31'd0, wrfull}, 32'd0);
    chk_q("fullwr_q", 8'd200);
    for (int i = 1; i < 32; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk_q($sformatf("fulldrain%0d_q", i), 8'(200 + i));
    end
    chk("fulldrain_empty", {31'd0, rdempty}, 32'd1);

    // Reset mid-stream after five writes.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 8'(50 + i));
    chk("mid_used5", {27'd0, wrusedw}, 32'd5);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("midrst_empty", {31'd0, rdempty}, 32'd1);
    chk("midrst_used", {27'd0, wrusedw}, 32'd0);
    chk_q("midrst_q", 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'hC3);
    chk("midrst_wr_used", {27'd0, wrusedw}, 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk_q("midrst_rd_q", 8'hC3);
    chk("midrst_rd_empty", {31'd0, rdempty}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_2clk.md
# fifo_2clk

- Synchronous first-in/first-out buffer: 32 words of 8 bits, one clock domain.
- Decouples a byte producer from a byte consumer.
- Provides an empty flag on the read side and a full flag plus fill count on the write side.
- Write and read ports use independent request strobes.

## Interface
Parameters:
- DATA_WIDTH, 8: word width of data and q.
- ADDR_WIDTH, 5: address width; depth = 2**ADDR_WIDTH = 32 words.

Ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- data  input  DATA_WIDTH  write word.
- wrreq  input  1  write request, sampled each rising edge.
- rdreq  input  1  read request, sampled each rising edge.
- q  output  DATA_WIDTH  read word.
- rdempty  output  1  high when the FIFO holds 0 words.
- wrfull  output  1  high when the FIFO holds 32 words.
- wrusedw  output  ADDR_WIDTH  stored-word count modulo 32.

## Operation
- Storage:
  - 32-entry array.
  - Write pointer and read pointer, each ADDR_WIDTH bits, wrapping 31 -> 0.
  - Occupancy counter, ADDR_WIDTH+1 bits, range 0..32.
- Write acceptance: wr_ok = wrreq & ~wrfull.
  - mem[wptr] <= data.
  - wptr increments.
- Read acceptance: rd_ok = rdreq & ~rdempty.
  - rptr increments.
  - q updated as described in Configuration.
- Counter update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged when both or neither are accepted.
- Flags are derived from the counter value after the edge:
  - rdempty = (count == 0).
  - wrfull = (count == 32).
  - wrusedw = count[ADDR_WIDTH-1:0], so it reads 0 when full; wrfull disambiguates.
- Overflow: wrreq while wrfull is high is ignored; data, pointers and count are unchanged.
- Underflow: rdreq while rdempty is high is ignored; pointers, count and q are unchanged.
- Stored data is never corrupted by ignored requests.

## Timing
- Reset (rst high at a rising edge):
  - wptr = rptr = 0, count = 0.
  - rdempty = 1, wrfull = 0, wrusedw = 0, q = 0.
  - Memory contents are not cleared.
- Reset has priority over wrreq and rdreq in the same cycle.
- Reset mid-operation discards all stored words at that edge.
- Flags and wrusedw are registered and change on the same edge as the accepted request.
- Write-to-read latency: a word written at edge N makes rdempty fall after edge N. It is readable by rdreq sampled at edge N+1.
- Simultaneous requests are evaluated on pre-edge flags:
  - Empty + wrreq + rdreq: only the write is accepted, count becomes 1, q holds.
  - Full + wrreq + rdreq: only the read is accepted, count becomes 31.
  - Otherwise, with both accepted, count holds and the pointers advance together.
- Pointer wrap-around needs no special handling: 31 + 1 = 0.

## Configuration
- Macro FIFO_2CLK_SHOWAHEAD_EN.
- Undefined (normal mode):
  - q is a register loaded with mem[rptr] at the edge where rd_ok is true.
  - Data appears one cycle after the request edge.
  - q holds its value otherwise.
- Defined (show-ahead mode):
  - q = mem[rptr] continuously while rdempty is low; rdreq acknowledges and advances to the next word.
  - q = 0 while rdempty is high.
- Flags, counts and acceptance rules are identical in both modes.

## Test plan
- Reset:
  - Stimulus: assert rst for 2 cycles.
  - Required: rdempty = 1, wrfull = 0, wrusedw = 0, q = 0.
- Fill:
  - Stimulus: wrreq = 1 for 32 cycles with data 1..32 incrementing each cycle.
  - Required: wrusedw steps 1..31 then reads 0, with wrfull = 1 on the 32nd edge.
  - Required: a 33rd write (data = 33) is ignored.
- Drain:
  - Stimulus: rdreq = 1 for 33 cycles on the full FIFO.
  - Required: q sequence is 1..32 in order, and rdempty = 1 after the 32nd read.
  - Required: the 33rd read leaves q = 32 in normal mode.
- Simultaneous:
  - Stimulus: with 10 stored words, assert wrreq and rdreq for 20 cycles.
  - Required: wrusedw stays 10, and output data continues in order.
- Boundary simultaneous:
  - Stimulus: wrreq + rdreq on empty.
  - Required: count becomes 1.
  - Stimulus: wrreq + rdreq on full.
  - Required: count becomes 31, wrfull = 0.
- Reset mid-stream:
  - Stimulus: after 5 writes, assert rst for 1 cycle.
  - Required: rdempty = 1, wrusedw = 0.
  - Required: a subsequent write then read returns the new word.
